// File: rtl/pifo_calendar_ctrl.sv
// PIFO calendar front end: enqueue FIFO, root packing, insert/pop arbitration.
// Define PIFO_CTRL_POP_PRIORITY_EN to let pop win every insert/pop conflict.
module pifo_calendar_ctrl #(
   parameter int BUFFER_ADDR_WIDTH         = 12,
   parameter int PIFO_RANK_WIDTH           = 19,
   parameter int PIFO_ROOT_WIDTH           = 32,
   parameter int ROOT_RANK_START_POS       = 12,
   parameter int ROOT_PIFO_INFO_VALID_POS  = 31,
   parameter int PIFO_CALENDAR_SIZE        = 1024,
   parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
   parameter int ENQ_FIFO_DEPTH            = 4,
   parameter int ENQ_FIFO_ADDR_WIDTH       = 2
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [BUFFER_ADDR_WIDTH-1:0]         s_axis_enq_addr,
   input  logic [PIFO_RANK_WIDTH-1:0]           s_axis_enq_rank,
   input  logic                                 s_axis_enq_valid,
   output logic                                 s_axis_enq_ready,
   output logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_deq_addr,
   output logic                                 m_axis_deq_valid,
   input  logic                                 m_axis_deq_ready,
   output logic [PIFO_ROOT_WIDTH-1:0]           m_pifo_info_root,
   output logic                                 m_pifo_insert_en,
   output logic                                 m_pifo_pop_en,
   input  logic [BUFFER_ADDR_WIDTH-1:0]         s_pifo_buffer_addr,
   input  logic                                 s_pifo_buffer_addr_valid,
   input  logic                                 s_pifo_calendar_full,
   output logic [PIFO_CALENDAR_INDEX_WIDTH:0]   m_axis_occupancy
);

   localparam int OCC_W = PIFO_CALENDAR_INDEX_WIDTH + 1;
   localparam int FA    = ENQ_FIFO_ADDR_WIDTH;
   localparam logic [OCC_W-1:0] CAL_SIZE =
      OCC_W'(PIFO_CALENDAR_SIZE);

   typedef struct packed {
      logic [BUFFER_ADDR_WIDTH-1:0] addr;
      logic [PIFO_RANK_WIDTH-1:0]   rank;
   } enq_desc_t;

   enq_desc_t                    fifo_mem [ENQ_FIFO_DEPTH];
   logic [FA:0]                  wr_ptr;
   logic [FA:0]                  rd_ptr;
   logic                         fifo_empty;
   logic                         fifo_full;
   logic                         fifo_wr;
   enq_desc_t                    head;

   logic [OCC_W-1:0]             occupancy;
   logic                         deq_valid;
   logic [BUFFER_ADDR_WIDTH-1:0] deq_addr;

   logic                         ins_cand;
   logic                         pop_cand;
   logic                         ins_grant;
   logic                         pop_grant;

   // Extra pointer bit separates full from empty.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FA] != rd_ptr[FA]) &&
                       (wr_ptr[FA-1:0] == rd_ptr[FA-1:0]);
   assign fifo_wr    = s_axis_enq_valid & ~fifo_full;
   assign head       = fifo_mem[rd_ptr[FA-1:0]];

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr[FA-1:0]] <= {s_axis_enq_addr,
                                      s_axis_enq_rank};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + (FA+1)'(1);
         end
         if (ins_grant) begin
            rd_ptr <= rd_ptr + (FA+1)'(1);
         end
      end
   end

   assign ins_cand = ~fifo_empty &
                     (occupancy < CAL_SIZE) &
                     ~s_pifo_calendar_full;

   assign pop_cand = s_pifo_buffer_addr_valid &
                     (occupancy != '0) &
                     (~deq_valid | m_axis_deq_ready);

`ifdef PIFO_CTRL_POP_PRIORITY_EN
   assign pop_grant = pop_cand;
   assign ins_grant = ins_cand & ~pop_cand;
`else
   logic last_pop;
   logic conflict;

   // last_pop resets to insert, so the first conflict goes to pop.
   assign conflict  = ins_cand & pop_cand;
   assign pop_grant = pop_cand & (~ins_cand | ~last_pop);
   assign ins_grant = ins_cand & (~pop_cand | last_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_pop <= 1'b0;
      end else if (conflict) begin
         last_pop <= pop_grant;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occupancy <= '0;
      end else begin
         unique case (1'b1)
            ins_grant: occupancy <= occupancy + OCC_W'(1);
            pop_grant: occupancy <= occupancy - OCC_W'(1);
            default:   occupancy <= occupancy;
         endcase
      end
   end

   // A pop reloads the holding register even while it drains.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         deq_valid <= 1'b0;
         deq_addr  <= '0;
      end else if (pop_grant) begin
         deq_valid <= 1'b1;
         deq_addr  <= s_pifo_buffer_addr;
      end else if (deq_valid && m_axis_deq_ready) begin
         deq_valid <= 1'b0;
      end
   end

   always_comb begin
      m_pifo_info_root = '0;
      if (ins_grant) begin
         m_pifo_info_root[BUFFER_ADDR_WIDTH-1:0] = head.addr;
         m_pifo_info_root[ROOT_RANK_START_POS +:
                          PIFO_RANK_WIDTH]       = head.rank;
         m_pifo_info_root[ROOT_PIFO_INFO_VALID_POS] = 1'b1;
      end
   end

   assign s_axis_enq_ready = ~fifo_full;
   assign m_pifo_insert_en = ins_grant;
   assign m_pifo_pop_en    = pop_grant;
   assign m_axis_deq_valid = deq_valid;
   assign m_axis_deq_addr  = deq_addr;
   assign m_axis_occupancy = occupancy;

   a_one_strobe: assert property (
      @(posedge clk) disable iff (!rstn)
      !(m_pifo_insert_en && m_pifo_pop_en));

   a_occ_bound: assert property (
      @(posedge clk) disable iff (!rstn)
      occupancy <= CAL_SIZE);

endmodule
